// File: rtl/adc_spi_reader.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_reader
// Description : Periodic MCP3201-style serial ADC reader (SPI mode 0) that
//               publishes a 12-bit sensor reading with a one-cycle valid strobe.
//               Optional macro ADC_MISO_SYNC_EN adds a 2-flop MISO synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_reader #(
    parameter int CLK_DIV       = 4,
    parameter int LEAD_BITS     = 3,
    parameter int DATA_W        = 12,
    parameter int SAMPLE_PERIOD = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              adc_miso,
    output logic              adc_sclk,
    output logic              adc_cs_n,
    output logic [DATA_W-1:0] sensor_reading,
    output logic              sample_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int c_HALVES = 2 * (LEAD_BITS + DATA_W);
    localparam int c_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_HALF_W = $clog2(c_HALVES);
    localparam int c_PER_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_HALF_W-1:0] c_HALF_LAST  = c_HALF_W'(c_HALVES - 1);
    localparam logic [c_HALF_W-1:0] c_DATA_HALF0 = c_HALF_W'(2 * LEAD_BITS);
    localparam logic [c_PER_W-1:0]  c_PER_LAST   = c_PER_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_PER_W-1:0]  r_timer;
    logic [c_PER_W-1:0]  w_timer_next;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_DIV_W-1:0]  w_div_next;
    logic [c_HALF_W-1:0] r_half;
    logic [c_HALF_W-1:0] w_half_next;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_next;
    logic [DATA_W-1:0]   w_shift_in;
    logic [DATA_W-1:0]   r_reading;
    logic [DATA_W-1:0]   w_reading_next;
    logic                r_sclk;
    logic                w_sclk_next;
    logic                r_cs_n;
    logic                w_cs_n_next;
    logic                r_valid;
    logic                w_valid_next;
    logic                r_busy;
    logic                r_overrun;
    logic                w_overrun_next;
    logic                w_tick;
    logic                w_div_end;
    logic                w_miso;

`ifdef ADC_MISO_SYNC_EN
    logic r_miso_s1;
    logic r_miso_s2;

    // The capture edge is two cycles late relative to the pin, so the high
    // half-period must be at least three cycles long.
    if (CLK_DIV < 3) begin : g_clk_div_chk
        $error("adc_spi_reader: CLK_DIV must be >= 3 with ADC_MISO_SYNC_EN");
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= adc_miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    assign w_miso = r_miso_s2;
`else
    if (CLK_DIV < 2) begin : g_clk_div_chk
        $error("adc_spi_reader: CLK_DIV must be >= 2");
    end

    assign w_miso = adc_miso;
`endif

    assign w_tick     = enable && (r_timer == '0);
    assign w_div_end  = (r_div == c_DIV_LAST);
    assign w_shift_in = {r_shift[DATA_W-2:0], w_miso};

    always_comb begin
        w_state_next   = r_state;
        w_div_next     = r_div;
        w_half_next    = r_half;
        w_shift_next   = r_shift;
        w_reading_next = r_reading;
        w_sclk_next    = r_sclk;
        w_cs_n_next    = r_cs_n;
        w_valid_next   = 1'b0;
        w_overrun_next = r_overrun | (w_tick && (r_state != S_IDLE));

        if (!enable) begin
            w_timer_next = '0;
        end else if (r_timer == c_PER_LAST) begin
            w_timer_next = '0;
        end else begin
            w_timer_next = r_timer + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_next = S_SETUP;
                    w_cs_n_next  = 1'b0;
                    w_div_next   = '0;
                    w_half_next  = '0;
                    w_shift_next = '0;
                end
            end
            S_SETUP: begin
                if (w_div_end) begin
                    w_state_next = S_SHIFT;
                    w_div_next   = '0;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_div_end) begin
                    w_div_next  = '0;
                    w_sclk_next = ~r_sclk;
                    // Falling edge: ADC data has been stable for the whole high half.
                    if (r_sclk && (r_half >= c_DATA_HALF0)) begin
                        w_shift_next = w_shift_in;
                    end
                    if (r_half == c_HALF_LAST) begin
                        w_state_next   = S_HOLD;
                        w_cs_n_next    = 1'b1;
                        w_reading_next = w_shift_in;
                        w_valid_next   = 1'b1;
                    end else begin
                        w_half_next = r_half + 1'b1;
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            S_HOLD: begin
                if (w_div_end) begin
                    w_state_next = S_IDLE;
                    w_div_next   = '0;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_div     <= '0;
            r_half    <= '0;
            r_shift   <= '0;
            r_reading <= '0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_div     <= w_div_next;
            r_half    <= w_half_next;
            r_shift   <= w_shift_next;
            r_reading <= w_reading_next;
            r_sclk    <= w_sclk_next;
            r_cs_n    <= w_cs_n_next;
            r_valid   <= w_valid_next;
            r_busy    <= (w_state_next != S_IDLE);
            r_overrun <= w_overrun_next;
        end
    end

    assign adc_sclk       = r_sclk;
    assign adc_cs_n       = r_cs_n;
    assign sensor_reading = r_reading;
    assign sample_valid   = r_valid;
    assign busy           = r_busy;
    assign overrun        = r_overrun;

endmodule
`default_nettype wire
